filter2d_gen: RTL

FILTER2D_GEN -- requirements
Module: filter2d_gen

---
 rtl/filter2d_gen_if.sv | 34 +++
 rtl/filter2d_gen.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/filter2d_gen_if.sv
// filter2d_gen_if -- control, coefficient and memory signals of the 3x3 filter.
//   start/finish/busy : frame handshake
//   cs/we/addr/din    : memory request issued by the filter
//   dout              : memory read data, valid the cycle after a read request
//   h_write/h_idx/h_data : coefficient load port
//   shift/border_mode : frame settings, latched when a frame starts
// Modport slave is the filter; modport master is the host/memory side.
interface filter2d_gen_if #(
  parameter int AW = 17
);
  logic                 start;
  logic                 finish;
  logic                 busy;
  logic                 cs;
  logic                 we;
  logic [AW-1:0]        addr;
  logic [7:0]           din;
  logic [7:0]           dout;
  logic                 h_write;
  logic [3:0]           h_idx;
  logic signed [7:0]    h_data;
  logic [3:0]           shift;
  logic                 border_mode;

  modport slave (
    input  start, dout, h_write, h_idx, h_data, shift, border_mode,
    output finish, busy, cs, we, addr, din
  );

  modport master (
    output start, dout, h_write, h_idx, h_data, shift, border_mode,
    input  finish, busy, cs, we, addr, din
  );
endinterface

// File: rtl/filter2d_gen.sv
// filter2d_gen -- 3x3 signed-coefficient convolution over an IMG_W x IMG_H
// 8-bit image in a shared single-port memory.
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   bus     : filter2d_gen_if.slave (handshake, memory port, coefficient port)
// Each output pixel takes 9 read cycles (tap k in read cycle k), one
// accumulate cycle and one write cycle. All bus outputs are registered; their
// next values are derived from the next state and counters so that each
// request is present during the cycle the state machine names.
module filter2d_gen #(
  parameter int IMG_W    = 256,
  parameter int IMG_H    = 256,
  parameter int AW       = 17,
  parameter int SRC_BASE = 0,
  parameter int DST_BASE = 65536
) (
  input  logic             clk,
  input  logic             reset_n,
  filter2d_gen_if.slave    bus
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  typedef enum logic [2:0] {S_IDLE, S_RD, S_ACC, S_WR, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [3:0]          tap_q, tap_d;
  logic [RW-1:0]       row_q, row_d;
  logic [CW-1:0]       col_q, col_d;
  logic [3:0]          shift_q, shift_d;
  logic                border_q, border_d;
  logic signed [7:0]   coef_q [0:8];
  logic signed [19:0]  acc_q;
  logic                pend_q;
  logic [3:0]          pend_tap_q;
  logic                cs_q, cs_d, we_q, we_d, finish_q, busy_q;
  logic [AW-1:0]       addr_q, addr_d;
  logic [7:0]          din_q, din_d;
  logic signed [7:0]   coef_sel_s;
  logic signed [19:0]  prod_s, acc_sum_s;
  logic [7:0]          result_s;
  logic [AW:0]         req_s;

  // Read request for a tap: {valid, address}; valid=0 means zero-padded tap.
  function automatic logic [AW:0] tap_req(input logic [3:0] tap, input int row,
                                          input int col, input logic border);
    int y;
    int x;
    logic [AW:0] r;
    y = row + int'(tap) / 3 - 1;
    x = col + int'(tap) % 3 - 1;
    if (y < 0 || y > IMG_H - 1 || x < 0 || x > IMG_W - 1) begin
      if (border) begin
        y = (y < 0) ? 0 : ((y > IMG_H - 1) ? IMG_H - 1 : y);
        x = (x < 0) ? 0 : ((x > IMG_W - 1) ? IMG_W - 1 : x);
        r = {1'b1, AW'(SRC_BASE + y * IMG_W + x)};
      end else begin
        r = '0;
      end
    end else begin
      r = {1'b1, AW'(SRC_BASE + y * IMG_W + x)};
    end
    return r;
  endfunction

  // Round-half-up, arithmetic shift right, clamp to 0..255.
  function automatic logic [7:0] saturate_result(input logic signed [19:0] acc,
                                                 input logic [3:0] sh);
    logic signed [20:0] sum;
    logic signed [20:0] rnd;
    logic [7:0] r;
    rnd = (sh != 4'd0) ? (21'sd1 <<< (sh - 4'd1)) : 21'sd0;
    sum = $signed({acc[19], acc}) + rnd;
    sum = sum >>> sh;
    if (sum < 21'sd0) begin
      r = 8'd0;
    end else if (sum > 21'sd255) begin
      r = 8'd255;
    end else begin
      r = sum[7:0];
    end
    return r;
  endfunction

  // Product of the returning pixel and its tap coefficient, plus running sum.
  always_comb begin
    coef_sel_s = coef_q[pend_tap_q];
    prod_s     = $signed({12'd0, bus.dout}) * $signed({{12{coef_sel_s[7]}}, coef_sel_s});
    acc_sum_s  = acc_q + (pend_q ? prod_s : 20'sd0);
    result_s   = saturate_result(acc_sum_s, shift_q);
  end

  // Next-state and counter logic.
  always_comb begin
    state_d  = state_q;
    tap_d    = tap_q;
    row_d    = row_q;
    col_d    = col_q;
    shift_d  = shift_q;
    border_d = border_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d  = S_RD;
          tap_d    = 4'd0;
          row_d    = '0;
          col_d    = '0;
          shift_d  = bus.shift;
          border_d = bus.border_mode;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD: begin
        if (tap_q == 4'd8) begin
          state_d = S_ACC;
        end else begin
          tap_d = tap_q + 4'd1;
        end
      end
      S_ACC: state_d = S_WR;
      S_WR: begin
        tap_d = 4'd0;
        if (col_q == CW'(IMG_W - 1)) begin
          col_d = '0;
          if (row_q == RW'(IMG_H - 1)) begin
            row_d   = '0;
            state_d = S_DONE;
          end else begin
            row_d   = row_q + RW'(1);
            state_d = S_RD;
          end
        end else begin
          col_d   = col_q + CW'(1);
          state_d = S_RD;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Memory request for the coming cycle, from the next state and counters.
  always_comb begin
    cs_d   = 1'b0;
    we_d   = 1'b0;
    addr_d = '0;
    din_d  = 8'd0;
    req_s  = tap_req(tap_d, int'(row_d), int'(col_d), border_d);
    case (state_d)
      S_RD: begin
        cs_d   = req_s[AW];
        addr_d = req_s[AW-1:0];
      end
      S_WR: begin
        cs_d   = 1'b1;
        we_d   = 1'b1;
        addr_d = AW'(DST_BASE + int'(row_d) * IMG_W + int'(col_d));
        din_d  = result_s;
      end
      default: begin
        cs_d = 1'b0;
      end
    endcase
  end

  // State, counters, latched settings and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      tap_q    <= 4'd0;
      row_q    <= '0;
      col_q    <= '0;
      shift_q  <= 4'd0;
      border_q <= 1'b0;
      cs_q     <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      din_q    <= 8'd0;
      finish_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tap_q    <= tap_d;
      row_q    <= row_d;
      col_q    <= col_d;
      shift_q  <= shift_d;
      border_q <= border_d;
      cs_q     <= cs_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      finish_q <= (state_d == S_DONE);
      busy_q   <= (state_d != S_IDLE);
    end
  end

  // Accumulator: read data arrives one cycle after its request; tap 0's
  // request cycle has nothing returning, so the sum is cleared there.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q      <= 20'sd0;
      pend_q     <= 1'b0;
      pend_tap_q <= 4'd0;
    end else begin
      pend_q     <= cs_q & ~we_q;
      pend_tap_q <= tap_q;
      if (state_q == S_RD && tap_q == 4'd0) begin
        acc_q <= 20'sd0;
      end else begin
        acc_q <= acc_sum_s;
      end
    end
  end

  // Coefficient bank, writable only while idle; resets to identity kernel.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 9; i++) begin
        coef_q[i] <= (i == 4) ? 8'sd1 : 8'sd0;
      end
    end else if (state_q == S_IDLE && bus.h_write && bus.h_idx <= 4'd8) begin
      coef_q[bus.h_idx] <= bus.h_data;
    end
  end

  assign bus.cs     = cs_q;
  assign bus.we     = we_q;
  assign bus.addr   = addr_q;
  assign bus.din    = din_q;
  assign bus.finish = finish_q;
  assign bus.busy   = busy_q;

endmodule
